ps2_keycode_rx: RTL and testbench

PS/2 keyboard front end for the two-player game: receives set-2 scan-code frames from the PS/2 port and decodes make/break sequences. It maintains a four-key rollover register. The 32-bit `keycode` output drives the game logic's PS/2 keycode input directly; each byte holds one currently held key's make code, and 0x00 means the slot is empty.

---
 rtl/ps2_pkg.sv | 36 +++
 rtl/ps2_frame_rx.sv | 129 ++++++++++++
 rtl/ps2_keycode_rx.sv | 97 +++++++++
 tb/tb_ps2_keycode_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_e;

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_PAUSE = 8'hE1;

    localparam int unsigned PAUSE_SKIP = 7;
    localparam int unsigned NUM_SLOTS  = 4;

    // Keyboard status/handshake bytes that carry no key information
    localparam logic [7:0] CODE_NULL    = 8'h00;
    localparam logic [7:0] CODE_BAT_OK  = 8'hAA;
    localparam logic [7:0] CODE_ACK     = 8'hFA;
    localparam logic [7:0] CODE_RESEND  = 8'hFE;
    localparam logic [7:0] CODE_OVERRUN = 8'hFF;

    typedef struct packed {
        logic [7:0] code;
        logic       valid;
        logic       err;
    } ps2_rx_t;

    function automatic logic is_ignored(input logic [7:0] code);
        return (code == CODE_NULL)   || (code == CODE_BAT_OK) || (code == CODE_ACK) ||
               (code == CODE_RESEND) || (code == CODE_OVERRUN);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame receiver with odd parity check and
// inactivity timeout; emits one registered byte/valid/error record per frame.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    ps2_clk_i,
    input  logic    ps2_dat_i,
    output ps2_rx_t rx_o
);

    localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

    logic [1:0]        clk_sync_q, dat_sync_q;
    logic              filt_q, filt_d, filt_prev_q;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;

    frame_state_e      state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    ps2_rx_t           rx_q, rx_d;

    logic              sample_c;
    logic              dat_c;

    assign sample_c = filt_prev_q & ~filt_q;
    assign dat_c    = dat_sync_q[1];
    assign rx_o     = rx_q;

    // Glitch filter: the filtered clock follows only a stable run of differing samples
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + FILT_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        rx_d      = '0;
        rx_d.code = rx_q.code;
        if (sample_c) begin
            tmo_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!dat_c) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_c, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = dat_c;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (dat_c && (^{shift_q, par_q})) begin
                        rx_d.valid = 1'b1;
                        rx_d.code  = shift_q;
                    end else begin
                        rx_d.err = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            // A stalled keyboard must not leave the receiver mid-frame forever
            if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                state_d  = ST_IDLE;
                tmo_d    = '0;
                rx_d.err = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            rx_q        <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q  <= {dat_sync_q[0], ps2_dat_i};
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            rx_q        <= rx_d;
        end
    end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 make/break decoder feeding a four-slot key rollover register.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic [31:0] keycode,
    output logic [7:0]  scan_code,
    output logic        scan_valid,
    output logic        frame_err
);

    localparam int unsigned SKIP_W = $clog2(PAUSE_SKIP + 1);

    ps2_rx_t rx;

    logic                       ext_q, ext_d;
    logic                       brk_q, brk_d;
    logic [SKIP_W-1:0]          skip_q, skip_d;
    logic [NUM_SLOTS-1:0][7:0]  slot_q, slot_d;
    logic                       hit_c, placed_c;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .ps2_clk_i (PS2_CLK),
        .ps2_dat_i (PS2_DAT),
        .rx_o      (rx)
    );

    assign keycode    = slot_q;
    assign scan_code  = rx.code;
    assign scan_valid = rx.valid;
    assign frame_err  = rx.err;

    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        skip_d   = skip_q;
        slot_d   = slot_q;
        hit_c    = 1'b0;
        placed_c = 1'b0;
        if (rx.valid) begin
            if (skip_q != '0) begin
                skip_d = skip_q - SKIP_W'(1);
            end else if (rx.code == CODE_EXT) begin
                ext_d = 1'b1;
            end else if (rx.code == CODE_BRK) begin
                brk_d = 1'b1;
            end else if (rx.code == CODE_PAUSE) begin
                skip_d = SKIP_W'(PAUSE_SKIP);
            end else if (!is_ignored(rx.code)) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (brk_q) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (slot_q[i] == rx.code) slot_d[i] = 8'h00;
                    end
                end else begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (slot_q[i] == rx.code) hit_c = 1'b1;
                    end
                    // Lowest empty slot wins; a full register silently drops the key
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (!hit_c && !placed_c && slot_q[i] == 8'h00) begin
                            slot_d[i] = rx.code;
                            placed_c  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= '0;
            slot_q <= '0;
        end else begin
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            skip_q <= skip_d;
            slot_q <= slot_d;
        end
    end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: frame table plus timeout, latency and reset sequences.
module tb_ps2_keycode_rx;

    localparam int FL   = 4;
    localparam int TMO  = 200;
    localparam int HALF = 20;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        PS2_CLK = 1'b1;
    logic        PS2_DAT = 1'b1;
    logic [31:0] keycode;
    logic [7:0]  scan_code;
    logic        scan_valid;
    logic        frame_err;

    ps2_keycode_rx #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .PS2_CLK    (PS2_CLK),
        .PS2_DAT    (PS2_DAT),
        .keycode    (keycode),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0]  code;
        bit          par_ok;
        bit          stop;
        logic [31:0] key;
        int          nv;
        int          ne;
        logic [7:0]  sc;
    } vec_t;

    vec_t tv[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int viol = 0;
    int valid_cyc = 0;
    int stop_cyc = 0;
    logic pv = 1'b0;
    logic pe = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Pulse monitor: counts pulses and flags overlap or pulses wider than one cycle
    always @(negedge Clk) begin
        if (scan_valid && frame_err) viol++;
        if (scan_valid && pv) viol++;
        if (frame_err && pe) viol++;
        if (scan_valid) begin
            valid_cnt++;
            valid_cyc = cyc;
        end
        if (frame_err) err_cnt++;
        pv = scan_valid;
        pe = frame_err;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit is_stop);
        PS2_DAT = b;
        tick(HALF / 2);
        PS2_CLK = 1'b0;
        if (is_stop) stop_cyc = cyc;
        tick(HALF);
        PS2_CLK = 1'b1;
        tick(HALF / 2);
    endtask

    // nbits < 8 sends a truncated frame (start plus nbits data bits only)
    task automatic send_frame(input logic [7:0] code, input bit par_ok, input bit stop, input int nbits);
        logic par;
        par = (~^code) ^ !par_ok;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(code[i], 1'b0);
        if (nbits == 8) begin
            send_bit(par, 1'b0);
            send_bit(stop, 1'b1);
        end
        PS2_DAT = 1'b1;
    endtask

    function automatic void add(input logic [7:0] c, input bit p, input bit s,
                                input logic [31:0] k, input int nv, input int ne, input logic [7:0] sc);
        vec_t v;
        v.code = c; v.par_ok = p; v.stop = s; v.key = k; v.nv = nv; v.ne = ne; v.sc = sc;
        tv.push_back(v);
    endfunction

    function automatic void ok(input logic [7:0] c, input logic [31:0] k);
        add(c, 1'b1, 1'b1, k, 1, 0, c);
    endfunction

    initial begin
        // Rollover fill, drop, break and refill
        ok(8'h1D, 32'h0000001D);
        ok(8'h1C, 32'h00001C1D);
        ok(8'h1B, 32'h001B1C1D);
        ok(8'h23, 32'h231B1C1D);
        ok(8'h75, 32'h231B1C1D);
        ok(8'hF0, 32'h231B1C1D);
        ok(8'h1C, 32'h231B001D);
        ok(8'h75, 32'h231B751D);
        ok(8'hF0, 32'h231B751D); ok(8'h1D, 32'h231B7500);
        ok(8'hF0, 32'h231B7500); ok(8'h1B, 32'h23007500);
        ok(8'hF0, 32'h23007500); ok(8'h23, 32'h00007500);
        ok(8'hF0, 32'h00007500); ok(8'h75, 32'h00000000);
        // Extended make and break
        ok(8'hE0, 32'h00000000); ok(8'h75, 32'h00000075);
        ok(8'hE0, 32'h00000075); ok(8'hF0, 32'h00000075); ok(8'h75, 32'h00000000);
        // Duplicate make
        ok(8'h1D, 32'h0000001D); ok(8'h1D, 32'h0000001D);
        // Bad parity and bad stop bit
        add(8'h1D, 1'b0, 1'b1, 32'h0000001D, 0, 1, 8'h1D);
        add(8'h1C, 1'b1, 1'b0, 32'h0000001D, 0, 1, 8'h1D);
        // Pause sequence and status bytes change nothing
        ok(8'hE1, 32'h0000001D); ok(8'h14, 32'h0000001D); ok(8'h77, 32'h0000001D);
        ok(8'hE1, 32'h0000001D); ok(8'hF0, 32'h0000001D); ok(8'h14, 32'h0000001D);
        ok(8'hF0, 32'h0000001D); ok(8'h77, 32'h0000001D);
        ok(8'hAA, 32'h0000001D); ok(8'hFA, 32'h0000001D);
        ok(8'h1C, 32'h00001C1D);

        tick(3);
        check("reset keycode", keycode, 32'h0);
        check("reset scan_code", 32'(scan_code), 32'h0);
        check("reset pulses", {30'h0, scan_valid, frame_err}, 32'h0);
        Reset_n = 1'b1;
        tick(5);

        foreach (tv[i]) begin
            valid_cnt = 0;
            err_cnt = 0;
            send_frame(tv[i].code, tv[i].par_ok, tv[i].stop, 8);
            tick(4);
            check($sformatf("row%0d valid_cnt", i), 32'(valid_cnt), 32'(tv[i].nv));
            check($sformatf("row%0d err_cnt", i), 32'(err_cnt), 32'(tv[i].ne));
            check($sformatf("row%0d keycode", i), keycode, tv[i].key);
            check($sformatf("row%0d scan_code", i), 32'(scan_code), 32'(tv[i].sc));
        end

        // Stop-bit clock fall to scan_valid latency
        valid_cnt = 0;
        send_frame(8'hF0, 1'b1, 1'b1, 8);
        tick(4);
        check("latency valid_cnt", 32'(valid_cnt), 32'd1);
        check("latency window", 32'((valid_cyc - stop_cyc >= FL + 1) && (valid_cyc - stop_cyc <= FL + 4)), 32'd1);

        // Back-to-back frames, no gap after the stop bit
        valid_cnt = 0;
        send_frame(8'h1C, 1'b1, 1'b1, 8);
        send_frame(8'h23, 1'b1, 1'b1, 8);
        tick(4);
        check("b2b valid_cnt", 32'(valid_cnt), 32'd2);
        check("b2b keycode", keycode, 32'h0000231D);

        // Timeout after five data bits, then a clean frame
        valid_cnt = 0;
        err_cnt = 0;
        send_frame(8'h55, 1'b1, 1'b1, 5);
        tick(TMO + 50);
        check("timeout err_cnt", 32'(err_cnt), 32'd1);
        check("timeout valid_cnt", 32'(valid_cnt), 32'd0);
        send_frame(8'h1C, 1'b1, 1'b1, 8);
        tick(4);
        check("post-timeout valid_cnt", 32'(valid_cnt), 32'd1);
        check("post-timeout scan_code", 32'(scan_code), 32'h1C);
        check("post-timeout keycode", keycode, 32'h001C231D);

        // Reset asserted mid-frame
        send_frame(8'h23, 1'b1, 1'b1, 4);
        Reset_n = 1'b0;
        tick(2);
        check("midreset keycode", keycode, 32'h0);
        check("midreset scan_code", 32'(scan_code), 32'h0);
        check("midreset pulses", {30'h0, scan_valid, frame_err}, 32'h0);
        Reset_n = 1'b1;
        tick(5);
        valid_cnt = 0;
        err_cnt = 0;
        send_frame(8'h1B, 1'b1, 1'b1, 8);
        tick(4);
        check("post-reset valid_cnt", 32'(valid_cnt), 32'd1);
        check("post-reset err_cnt", 32'(err_cnt), 32'd0);
        check("post-reset keycode", keycode, 32'h0000001B);
        check("post-reset scan_code", 32'(scan_code), 32'h1B);

        check("pulse shape violations", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
